// File: rtl/pong_pkg.sv
// Shared definitions for the player input front-end.
//   MODE_ENCODER / MODE_BUTTONS : per-channel decode mode values
//   step_e                      : one-cycle step request (none, up = -1 row, down = +1 row)
//   center_row()                : rest position of a paddle of length plen in rows
//   paddle_bitmap()             : PLEN ones starting at row pos, callers cast to ROWS bits
//   button_sel()                : which single button is held, or STEP_NONE
package pong_pkg;

  localparam logic MODE_ENCODER = 1'b0;
  localparam logic MODE_BUTTONS = 1'b1;

  // Widest playfield the bitmap helper supports.
  localparam int BITMAP_MAX = 256;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10
  } step_e;

  function automatic int center_row(input int rows, input int plen);
    return (rows - plen) / 2;
  endfunction

  function automatic logic [BITMAP_MAX-1:0] paddle_bitmap(input int pos, input int plen);
    logic [BITMAP_MAX-1:0] bm;
    bm = '0;
    for (int i = 0; i < BITMAP_MAX; i++) begin
      bm[i] = (i >= pos) && (i < pos + plen);
    end
    return bm;
  endfunction

  // Exactly one button held selects its direction; both or neither select nothing.
  function automatic step_e button_sel(input logic up, input logic dn);
    if (up && !dn) return STEP_UP;
    if (dn && !up) return STEP_DOWN;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/paddle_input_channel.sv
// One player channel: 2-flop synchronisers, strobe-gated debounce, encoder or
// button decode with autorepeat, saturating paddle position and bitmap.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   sample_en_i       : debounce / autorepeat tick
//   mode_i            : MODE_ENCODER or MODE_BUTTONS
//   center_i          : recentre request, wins over a coincident step
//   a_i, b_i          : raw lines (encoder A/B or button up/down)
//   pos_o             : paddle top row
//   paddle_o          : paddle bitmap, one clk behind pos_o
//   moved_o           : one-cycle pulse when pos_o changed
module paddle_input_channel
  import pong_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int PLEN         = 8,
  parameter int DEBOUNCE     = 16,   // must be at least 2
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100,  // must not exceed REPEAT_DELAY
  parameter int POSW         = $clog2(ROWS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sample_en_i,
  input  logic            mode_i,
  input  logic            center_i,
  input  logic            a_i,
  input  logic            b_i,
  output logic [POSW-1:0] pos_o,
  output logic [ROWS-1:0] paddle_o,
  output logic            moved_o
);

  localparam int              CNTW       = $clog2(REPEAT_DELAY + 1);
  localparam logic [POSW-1:0] CENTER     = POSW'(center_row(ROWS, PLEN));
  localparam logic [POSW-1:0] POS_MAX    = POSW'(ROWS - PLEN);
  localparam logic [CNTW-1:0] RPT_FIRST  = CNTW'(REPEAT_DELAY);
  localparam logic [CNTW-1:0] RPT_RELOAD = CNTW'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [ROWS-1:0] BM_CENTER  = ROWS'(paddle_bitmap(center_row(ROWS, PLEN), PLEN));

  logic [1:0]          a_sync_q, b_sync_q;     // bit 1 is the synchronised level
  logic [DEBOUNCE-1:0] a_hist_q, a_hist_d, b_hist_q, b_hist_d;
  logic                a_db_q, a_db_d, b_db_q, b_db_d;
  logic                a_prev_q, b_prev_q;     // debounced levels one clk earlier
  logic                tick_q;                 // debounced levels came from a tick
  logic                mode_q;
  logic [CNTW-1:0]     cnt_q, cnt_d, cnt_inc;
  step_e               step_q, step_d, cur_sel, prev_sel;
  logic [POSW-1:0]     pos_q, pos_d;
  logic                moved_q, moved_d;
  logic [ROWS-1:0]     paddle_q, paddle_d;

  // Debounce: a level is accepted only when the whole history agrees.
  always_comb begin
    a_hist_d = a_hist_q;
    b_hist_d = b_hist_q;
    a_db_d   = a_db_q;
    b_db_d   = b_db_q;
    if (sample_en_i) begin
      a_hist_d = {a_hist_q[DEBOUNCE-2:0], a_sync_q[1]};
      b_hist_d = {b_hist_q[DEBOUNCE-2:0], b_sync_q[1]};
      if (&a_hist_d)       a_db_d = 1'b1;
      else if (~|a_hist_d) a_db_d = 1'b0;
      if (&b_hist_d)       b_db_d = 1'b1;
      else if (~|b_hist_d) b_db_d = 1'b0;
    end
  end

  // Step decode. A pending mode change suppresses decoding for that cycle so
  // the switch never produces a step, and restarts the repeat counter.
  assign cur_sel  = button_sel(a_db_q, b_db_q);
  assign prev_sel = button_sel(a_prev_q, b_prev_q);
  assign cnt_inc  = cnt_q + CNTW'(1);

  always_comb begin
    step_d = STEP_NONE;
    cnt_d  = cnt_q;
    if (mode_i != mode_q) begin
      cnt_d = '0;
    end else if (mode_q == MODE_ENCODER) begin
      cnt_d = '0;
      if (a_db_q && !a_prev_q) step_d = b_db_q ? STEP_UP : STEP_DOWN;
    end else if (cur_sel == STEP_NONE) begin
      cnt_d = '0;
    end else if (cur_sel != prev_sel) begin
      // New press, including the survivor when one of two held buttons lifts.
      step_d = cur_sel;
      cnt_d  = '0;
    end else if (tick_q) begin
      // Reloading to DELAY-RATE makes every later repeat REPEAT_RATE ticks apart.
      if (cnt_inc == RPT_FIRST) begin
        step_d = cur_sel;
        cnt_d  = RPT_RELOAD;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Position: saturating, recentre wins, moved only on a real change.
  always_comb begin
    pos_d = pos_q;
    if (center_i) begin
      pos_d = CENTER;
    end else begin
      case (step_q)
        STEP_UP:   if (pos_q != '0)     pos_d = pos_q - POSW'(1);
        STEP_DOWN: if (pos_q != POS_MAX) pos_d = pos_q + POSW'(1);
        default:   pos_d = pos_q;
      endcase
    end
    moved_d  = (pos_d != pos_q);
    paddle_d = ROWS'(paddle_bitmap(int'(pos_q), PLEN));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_hist_q <= '0;
      b_hist_q <= '0;
      a_db_q   <= 1'b0;
      b_db_q   <= 1'b0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      tick_q   <= 1'b0;
      mode_q   <= MODE_ENCODER;
      cnt_q    <= '0;
      step_q   <= STEP_NONE;
      pos_q    <= CENTER;
      moved_q  <= 1'b0;
      paddle_q <= BM_CENTER;
    end else begin
      a_sync_q <= {a_sync_q[0], a_i};
      b_sync_q <= {b_sync_q[0], b_i};
      a_hist_q <= a_hist_d;
      b_hist_q <= b_hist_d;
      a_db_q   <= a_db_d;
      b_db_q   <= b_db_d;
      a_prev_q <= a_db_q;
      b_prev_q <= b_db_q;
      tick_q   <= sample_en_i;
      mode_q   <= mode_i;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      moved_q  <= moved_d;
      paddle_q <= paddle_d;
    end
  end

  assign pos_o    = pos_q;
  assign paddle_o = paddle_q;
  assign moved_o  = moved_q;

endmodule

// File: rtl/paddle_input_array.sv
// NCH independent paddle input channels sharing clock, reset and sample strobe.
//   clk, reset, sample_en : shared clock, async active-high reset, tick strobe
//   mode, center          : per-channel decode mode and recentre request
//   in_a, in_b            : per-channel raw lines
//   pos_o                 : channel i at [i*POSW +: POSW]
//   paddle_o              : channel i at [i*ROWS +: ROWS]
//   moved_o               : per-channel moved pulse
module paddle_input_array #(
  parameter int NCH          = 2,
  parameter int ROWS         = 32,
  parameter int PLEN         = 8,
  parameter int DEBOUNCE     = 16,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100,
  parameter int POSW         = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [NCH-1:0]      mode,
  input  logic [NCH-1:0]      center,
  input  logic [NCH-1:0]      in_a,
  input  logic [NCH-1:0]      in_b,
  output logic [NCH*POSW-1:0] pos_o,
  output logic [NCH*ROWS-1:0] paddle_o,
  output logic [NCH-1:0]      moved_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    paddle_input_channel #(
      .ROWS         (ROWS),
      .PLEN         (PLEN),
      .DEBOUNCE     (DEBOUNCE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .POSW         (POSW)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (reset),
      .sample_en_i (sample_en),
      .mode_i      (mode[g]),
      .center_i    (center[g]),
      .a_i         (in_a[g]),
      .b_i         (in_b[g]),
      .pos_o       (pos_o[g*POSW +: POSW]),
      .paddle_o    (paddle_o[g*ROWS +: ROWS]),
      .moved_o     (moved_o[g])
    );
  end

endmodule

// File: doc/paddle_input_array.md
Name: paddle_input_array

Overview:
- Next-generation player input front-end: NCH independent channels in one clock domain.
- Each channel:
  - synchronises two raw switch/encoder lines;
  - debounces them on a shared sample strobe (clock-enable, not a derived clock);
  - decodes them as a quadrature encoder or as up/down buttons with autorepeat;
  - keeps a saturating paddle position and renders it as a ROWS-bit paddle bitmap for game, screen and vga consumers.
- Replaces the per-player debounce/rot_encoder/paddle chains.

Parameters:
- NCH, 2, number of player channels.
- ROWS, 32, paddle bitmap width (playfield rows).
- PLEN, 8, paddle length in rows; 1 ≤ PLEN < ROWS.
- DEBOUNCE, 16, consecutive equal samples required to accept a new level.
- REPEAT_DELAY, 400, sample ticks from press to first autorepeat step (button mode).
- REPEAT_RATE, 100, sample ticks between subsequent autorepeat steps.
- POSW, $clog2(ROWS), position width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-cycle debounce/autorepeat tick strobe.
- mode  in  NCH  per channel: 0 = quadrature encoder, 1 = up/down buttons.
- center  in  NCH  per channel: synchronous recentre request.
- in_a  in  NCH  raw line A (encoder A / button up).
- in_b  in  NCH  raw line B (encoder B / button down).
- pos_o  out  NCH*POSW  paddle top row; channel i at [i*POSW +: POSW].
- paddle_o  out  NCH*ROWS  paddle bitmap; channel i at [i*ROWS +: ROWS].
- moved_o  out  NCH  one-cycle pulse when pos_o of that channel changed.

Behaviour:
- Reset is asynchronous. While asserted:
  - synchronisers, history and debounced levels = 0;
  - autorepeat counters = 0;
  - pos = CENTER = (ROWS-PLEN)/2;
  - paddle_o = ((1<<PLEN)-1) << CENTER;
  - moved_o = 0.
- Reset mid-operation aborts any autorepeat or pending step immediately; nothing is remembered.
- Synchroniser: 2 flops per line, clocked every clk.
- Debounce:
  - on sample_en, shift the synchronised level into a DEBOUNCE-deep history;
  - when the post-shift history is all ones or all zeros, the debounced level takes that value in the same cycle;
  - no sample_en means no change.
- Step generation: registered, 1 clk after the debounced change.
- Encoder mode (mode=0):
  - on a rising edge of debounced A: step +1 (down) if debounced B=0, step -1 if B=1;
  - falling edges of A and any edges of B alone produce no step.
- Button mode (mode=1):
  - up = debounced A, down = debounced B;
  - a press edge of exactly one of them emits one step (-1 for up, +1 for down) and clears the repeat counter;
  - while held, counting sample_en ticks from the press: step at tick REPEAT_DELAY, then every REPEAT_RATE ticks;
  - both held, or neither held: no step, counter held at 0;
  - releasing one of two held buttons counts as a new press of the remaining one.
- Mode change mid-operation: takes effect next cycle; counter cleared, no spurious step.
- Position: updated the clk after the step.
  - center=1: pos ← CENTER. center has priority over a coincident step.
  - Else step -1: pos ← max(pos-1, 0); step +1: pos ← min(pos+1, ROWS-PLEN). Saturating, never wraps.
  - moved_o = 1 for exactly that cycle only if pos actually changed. A saturated step gives moved_o = 0.
- paddle_o:
  - registered, equals ((1<<PLEN)-1) << pos, lags pos_o by 1 clk;
  - PLEN bits set at all times.
- Latency from a debounced-level change: step at +1, pos_o/moved_o at +2, paddle_o at +3 clk.
- Channels are fully independent; simultaneous activity on all channels is handled in the same cycle.

Decomposition:
- Shared package pong_pkg:
  - MODE_ENCODER / MODE_BUTTONS constants;
  - step encoding (STEP_NONE, STEP_UP, STEP_DOWN);
  - function paddle_bitmap(pos) → ROWS bits;
  - CENTER constant function.
- Sub-module paddle_input_channel: synchroniser, debounce, decode, autorepeat, position, bitmap for one channel.
- Top-level paddle_input_array: a generate loop over NCH plus port slicing.

Test Plan:
Common settings: NCH=2, ROWS=32, PLEN=8, DEBOUNCE=4, REPEAT_DELAY=8, REPEAT_RATE=4, sample_en=1 every cycle unless stated.
1. Reset release → pos_o both = 12, paddle_o both = 0x000FF000, moved_o = 0; assert reset mid-hold → same values asynchronously.
2. Ch0 encoder, B=0, three clean A rising edges → pos 15, paddle 0x007F8000, three moved_o pulses; ch1 unchanged at 12.
3. Ch0 encoder, 30 down steps → pos saturates at 24, paddle 0xFF000000, moved_o absent after 12th step; A glitch high for 3 samples → no step.
4. Ch1 buttons, hold A 20 ticks past debounced press → steps at ticks 0, 8, 12, 16, 20 → pos 7, paddle 0x00007F80; hold A and B together → no movement.
5. Step and center coincide on ch0 at pos 20 → pos 12, moved_o = 1; center at pos 12 → moved_o = 0.
6. sample_en every 10th cycle, A toggled then stable → debounced change only after 4 strobes; outputs frozen between strobes.
